// File: rtl/rs_syndrome_serial.sv
// Symbol-serial Reed-Solomon syndrome calculator over GF(2^SYMBOL_WIDTH).
// Each accepted symbol (highest degree first) is Horner-accumulated into NSYM
// accumulators, one per root alpha^(FCR+j). When the N-th symbol arrives, the
// complete syndrome vector is registered into a single output beat. That beat
// is held under a valid/ready handshake.
//
// Handshake semantics (both ports): a transfer happens on a rising clock edge
// where valid and ready are both 1. A producer holding valid=1 keeps its data
// stable until that transfer. o_in_ready drops only while the final symbol of
// a codeword would overwrite an output beat that has not been consumed yet.
module rs_syndrome_serial #(
  parameter int          SYMBOL_WIDTH = 8,
  parameter int          N            = 18,
  parameter int          NSYM         = 2,
  parameter int unsigned PRIM_POLY    = 'h11D,
  parameter int          FCR          = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_flush,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  input  logic [SYMBOL_WIDTH-1:0]      i_in_sym,
  input  logic                         i_in_last,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [NSYM*SYMBOL_WIDTH-1:0] o_syn,
  output logic                         o_syn_nonzero,
  output logic                         o_frame_err
);

  localparam int SW = SYMBOL_WIDTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [SW-1:0] POLY_LO   = SW'(PRIM_POLY);
  localparam logic [CW-1:0] LAST_IDX  = CW'(N - 1);

  // GF(2^m) multiply. When b is an elaboration-time constant, this reduces to
  // a pure XOR network over the bits of a.
  function automatic logic [SW-1:0] gf_mul(input logic [SW-1:0] a,
                                           input logic [SW-1:0] b);
    logic [SW-1:0] p;
    logic [SW-1:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < SW; i++) begin
      if (b[i]) p = p ^ x;
      x = x[SW-1] ? ((x << 1) ^ POLY_LO) : (x << 1);
    end
    return p;
  endfunction

  // alpha^e with alpha = x (0x02), evaluated at elaboration.
  function automatic logic [SW-1:0] gf_pow_alpha(input int e);
    logic [SW-1:0] r;
    r = SW'(1);
    for (int i = 0; i < e; i++) r = gf_mul(r, SW'(2));
    return r;
  endfunction

  logic [CW-1:0]      r_count;
  logic [NSYM*SW-1:0] r_acc;
  logic               r_err_sticky;
  logic [NSYM*SW-1:0] r_syn;
  logic               r_syn_nonzero;
  logic               r_frame_err;
  logic               r_out_valid;

  logic [NSYM*SW-1:0] w_acc_next;
  logic               w_last;
  logic               w_beat;
  logic               w_final;

  // One Horner step per root: acc_j * alpha^(FCR+j) + symbol.
  for (genvar j = 0; j < NSYM; j++) begin : g_root
    localparam logic [SW-1:0] ROOT = gf_pow_alpha(FCR + j);
    assign w_acc_next[j*SW +: SW] = gf_mul(r_acc[j*SW +: SW], ROOT) ^ i_in_sym;
  end

  assign w_last     = (r_count == LAST_IDX);
  assign o_in_ready = ~(w_last & r_out_valid & ~i_out_ready);
  assign w_beat     = i_in_valid & o_in_ready;
  // A flush in the same cycle drops the symbol, so it can never complete a codeword.
  assign w_final    = w_beat & w_last & ~i_flush;

  // Accumulators, symbol counter and early-in_last tracker for the codeword in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count      <= '0;
      r_acc        <= '0;
      r_err_sticky <= 1'b0;
    end else if (i_flush) begin
      r_count      <= '0;
      r_acc        <= '0;
      r_err_sticky <= 1'b0;
    end else if (w_beat) begin
      if (w_last) begin
        r_count      <= '0;
        r_acc        <= '0;
        r_err_sticky <= 1'b0;
      end else begin
        r_count <= r_count + CW'(1);
        r_acc   <= w_acc_next;
        if (i_in_last) r_err_sticky <= 1'b1;
      end
    end
  end

  // Output beat: load on the final symbol, hold until consumed, reload in place if both coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_syn         <= '0;
      r_syn_nonzero <= 1'b0;
      r_frame_err   <= 1'b0;
      r_out_valid   <= 1'b0;
    end else if (w_final) begin
      r_syn         <= w_acc_next;
      r_syn_nonzero <= |w_acc_next;
      r_frame_err   <= r_err_sticky | ~i_in_last;
      r_out_valid   <= 1'b1;
    end else if (r_out_valid & i_out_ready) begin
      r_out_valid   <= 1'b0;
    end
  end

  assign o_syn         = r_syn;
  assign o_syn_nonzero = r_syn_nonzero;
  assign o_frame_err   = r_frame_err;
  assign o_out_valid   = r_out_valid;

endmodule
